// File: rtl/uart_tx_arb_if.sv
// Bundle between byte-stream requesters, the transmit arbiter and uart_driver.
// The master side drives requests and tx_ready; the slave side is the arbiter.
interface uart_tx_arb_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic [DATA_BITS-1:0]         tx_data;
  logic                         tx_valid;
  logic                         tx_ready;
  logic [NUM_REQ-1:0]           grant;
  logic                         busy;
  logic [15:0]                  timeout_count;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant, busy, timeout_count
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant, busy, timeout_count
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one UART transmit channel among NUM_REQ requesters.
// Define UART_TX_ARB_PRIORITY_EN to make requester 0 strict high priority at arbitration time.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_BITS   = 8,
  parameter int GAP_TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_arb_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [GW-1:0]      GAP_LAST  = GW'(GAP_TIMEOUT - 1);
  localparam logic [IW-1:0]      LAST_INIT = IW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] GRANT_LSB = NUM_REQ'(1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             state_q;
  logic [IW-1:0]      gnt_q;
  logic [IW-1:0]      last_q;
  logic [GW-1:0]      gap_q;
  logic [15:0]        tocnt_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               busy_q;

  logic [IW-1:0]      arb_pick_d;
  logic               owner_valid;
  logic               done_xfer;
  logic               timeout_hit;

  // First asserted requester searching cyclically from last+1, wrapping at NUM_REQ-1.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [IW-1:0]      last);
    logic [IW-1:0] pick;
    int            idx;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (v[IW'(idx)]) pick = IW'(idx);
    end
    return pick;
  endfunction

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    arb_pick_d = rr_pick(bus.req_valid, last_q);
`ifdef UART_TX_ARB_PRIORITY_EN
    if (bus.req_valid[0]) arb_pick_d = '0;
`endif
  end

  assign owner_valid = bus.req_valid[gnt_q];
  assign done_xfer   = (state_q == S_GRANT) && owner_valid && bus.tx_ready && bus.req_last[gnt_q];
  assign timeout_hit = (state_q == S_GRANT) && !owner_valid && (gap_q == GAP_LAST);

  // Datapath is a pure mux on the registered owner, so reset silences it at once.
  always_comb begin
    bus.tx_data   = '0;
    bus.tx_valid  = 1'b0;
    bus.req_ready = '0;
    if (state_q == S_GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_q == IW'(i)) bus.tx_data = bus.req_data[i*DATA_BITS +: DATA_BITS];
      end
      bus.tx_valid         = owner_valid;
      bus.req_ready[gnt_q] = bus.tx_ready;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_INIT;
      gap_q   <= '0;
      tocnt_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          gap_q <= '0;
          if (|bus.req_valid) begin
            state_q <= S_GRANT;
            gnt_q   <= arb_pick_d;
            grant_q <= GRANT_LSB << arb_pick_d;
            busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (done_xfer || timeout_hit) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            gap_q   <= '0;
`ifdef UART_TX_ARB_PRIORITY_EN
            if (gnt_q != '0) last_q <= gnt_q;
`else
            last_q <= gnt_q;
`endif
            if (timeout_hit && tocnt_q != 16'hFFFF) tocnt_q <= tocnt_q + 16'd1;
          end else if (owner_valid) begin
            // A tx_ready stall with data pending is not a gap.
            gap_q <= '0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.grant         = grant_q;
  assign bus.busy          = busy_q;
  assign bus.timeout_count = tocnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DB = 8;
  localparam int GT = 8;
`ifdef UART_TX_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arb_if #(.NUM_REQ(N), .DATA_BITS(DB)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .GAP_TIMEOUT(GT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DB-1:0] d);
    bus.req_data[i*DB +: DB] = d;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.tx_ready  = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Reference model: owner index (-1 = nobody), round-robin pointer, gap length, revoke count.
  int m_owner, m_last, m_gap, m_to;

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_gap   = 0;
    m_to    = 0;
  endtask

  task automatic model_release();
    if (!(PRIO && m_owner == 0)) m_last = m_owner;
    m_owner = -1;
    m_gap   = 0;
  endtask

  task automatic model_step();
    int c;
    if (m_owner < 0) begin
      if (PRIO && bus.req_valid[0]) m_owner = 0;
      else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (bus.req_valid[c]) begin
            m_owner = c;
            break;
          end
        end
      end
    end else if (bus.req_valid[m_owner]) begin
      m_gap = 0;
      if (bus.tx_ready && bus.req_last[m_owner]) model_release();
    end else if (m_gap == GT - 1) begin
      if (m_to < 65535) m_to++;
      model_release();
    end else begin
      m_gap++;
    end
  endtask

  typedef struct packed {
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic          tx_ready;
    logic [N-1:0]  e_grant;
    logic          e_busy;
    logic          e_tv;
    logic [DB-1:0] e_td;
    logic [N-1:0]  e_rr;
  } vec_t;

  vec_t         tbl [13];
  logic [DB-1:0] order [$];
  logic [DB-1:0] exp_ord [5];
  int           pulses, k, cyc;
  logic [N-1:0] e_grant, e_rr;
  logic [DB-1:0] e_td;
  logic         e_tv;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fairness: everyone streams 1-byte messages; data of requester i is 0xA0+i.
    tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hA0, 4'b0001};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[3]  = '{4'hF, 4'hF, 1'b0, 4'b0010, 1'b1, 1'b1, 8'hA1, 4'b0000};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA1, 4'b0010};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[6]  = '{4'hF, 4'hF, 1'b1, 4'b0100, 1'b1, 1'b1, 8'hA2, 4'b0100};
    tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[8]  = '{4'hF, 4'hF, 1'b1, 4'b1000, 1'b1, 1'b1, 8'hA3, 4'b1000};
    tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[10] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 1'b1, 8'hA0, 4'b0001};
    tbl[11] = '{4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 4'b0000};
    tbl[12] = '{4'hF, 4'hF, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA1, 4'b0010};

    do_reset();
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_timeouts", bus.timeout_count, 0);
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + DB'(i));
    for (int r = 0; r < 13; r++) begin
      bus.req_valid = tbl[r].valid;
      bus.req_last  = tbl[r].last;
      bus.tx_ready  = tbl[r].tx_ready;
      #1;
      check($sformatf("tbl%0d_grant", r), bus.grant, tbl[r].e_grant);
      check($sformatf("tbl%0d_busy", r), bus.busy, tbl[r].e_busy);
      check($sformatf("tbl%0d_tx_valid", r), bus.tx_valid, tbl[r].e_tv);
      check($sformatf("tbl%0d_tx_data", r), bus.tx_data, tbl[r].e_td);
      check($sformatf("tbl%0d_req_ready", r), bus.req_ready, tbl[r].e_rr);
      tick();
    end

    // Single 3-byte message from requester 2 with a slow UART.
    do_reset();
    bus.req_valid = 4'b0100;
    set_data(2, 8'h41);
    #1;
    check("msg_idle_grant", bus.grant, 0);
    tick();
    check("msg_grant", bus.grant, 4'b0100);
    pulses = 0;
    for (int b = 0; b < 3; b++) begin
      set_data(2, 8'h41 + DB'(b));
      bus.req_last = (b == 2) ? 4'b0100 : 4'b0000;
      for (int w = 0; w < 100; w++) begin
        bus.tx_ready = (w == 99);
        #1;
        if (bus.req_ready != 0) pulses++;
        if (w == 99) begin
          check($sformatf("msg_byte%0d_data", b), bus.tx_data, 8'h41 + DB'(b));
          check($sformatf("msg_byte%0d_ready", b), bus.req_ready, 4'b0100);
        end
        tick();
      end
    end
    bus.req_valid = '0;
    bus.tx_ready  = 1'b0;
    check("msg_pulses", pulses, 3);
    check("msg_end_busy", bus.busy, 0);
    check("msg_end_grant", bus.grant, 0);

    // Atomicity: requester 1 sends 4 bytes while requester 0 waits.
    do_reset();
    bus.req_valid = 4'b0010;
    bus.tx_ready  = 1'b1;
    set_data(1, 8'h10);
    tick();
    bus.req_valid[0] = 1'b1;
    bus.req_last[0]  = 1'b1;
    set_data(0, 8'hE0);
    order.delete();
    k   = 0;
    cyc = 0;
    while (order.size() < 5 && cyc < 40) begin
      set_data(1, 8'h10 + DB'(k));
      bus.req_last[1]  = (k == 3);
      bus.req_valid[1] = (k < 4);
      #1;
      if (bus.tx_valid && bus.tx_ready) begin
        order.push_back(bus.tx_data);
        if (bus.req_ready[1]) k++;
      end
      tick();
      cyc++;
    end
    exp_ord = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hE0};
    check("atom_count", order.size(), 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check($sformatf("atom_byte%0d", i), order[i], exp_ord[i]);

    // Gap timeout: requester 3 sends one byte without last, then goes silent.
    do_reset();
    bus.req_valid = 4'b1000;
    bus.tx_ready  = 1'b1;
    set_data(3, 8'h77);
    tick();
    #1;
    check("to_xfer_ready", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = '0;
    for (int i = 1; i < GT; i++) begin
      tick();
      check($sformatf("to_hold%0d", i), bus.busy, 1);
    end
    tick();
    check("to_busy", bus.busy, 0);
    check("to_grant", bus.grant, 0);
    check("to_count", bus.timeout_count, 1);

    // Owner returns exactly on the would-be timeout cycle: valid wins.
    bus.req_valid = 4'b1000;
    bus.tx_ready  = 1'b0;
    tick();
    check("vw_grant", bus.grant, 4'b1000);
    bus.req_valid = '0;
    repeat (GT - 1) tick();
    bus.req_valid = 4'b1000;
    tick();
    check("vw_busy", bus.busy, 1);
    check("vw_count", bus.timeout_count, 1);

    // UART stall with valid held: never a timeout.
    repeat (1000) tick();
    check("stall_busy", bus.busy, 1);
    check("stall_count", bus.timeout_count, 1);
    bus.tx_ready = 1'b1;
    bus.req_last = 4'b1000;
    tick();
    bus.req_valid = '0;
    bus.req_last  = '0;
    check("stall_end_busy", bus.busy, 0);

    // Asynchronous reset between bytes 2 and 3 of a message.
    bus.req_valid = 4'b0010;
    bus.tx_ready  = 1'b1;
    set_data(1, 8'h55);
    repeat (3) tick();
    #1;
    check("ar_pre_valid", bus.tx_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("ar_tx_valid", bus.tx_valid, 0);
    check("ar_req_ready", bus.req_ready, 0);
    check("ar_grant", bus.grant, 0);
    check("ar_busy", bus.busy, 0);
    check("ar_count", bus.timeout_count, 0);
    tick();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    tick();
    check("ar_first_grant", bus.grant, 4'b0001);
    check("ar_count_after", bus.timeout_count, 0);

    // Requester 0 just finished while 0 and 2 both request.
    do_reset();
    bus.req_valid = 4'b0101;
    bus.req_last  = 4'b0101;
    bus.tx_ready  = 1'b1;
    tick();
    check("prio_first", bus.grant, 4'b0001);
    tick();
    check("prio_gap_idle", bus.busy, 0);
    tick();
    check("prio_second", bus.grant, PRIO ? 4'b0001 : 4'b0100);

    // Randomized traffic against the reference model, alternating dense and sparse phases.
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i] = ($urandom_range(99) < (((c / 200) % 2) ? 15 : 75));
        bus.req_last[i]  = ($urandom_range(99) < 30);
        set_data(i, DB'($urandom));
      end
      bus.tx_ready = $urandom_range(1);
      #1;
      e_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
      e_tv    = (m_owner >= 0) && bus.req_valid[m_owner];
      e_td    = (m_owner >= 0) ? bus.req_data[m_owner*DB +: DB] : '0;
      e_rr    = (m_owner >= 0 && bus.tx_ready) ? e_grant : '0;
      check("rnd_grant", bus.grant, e_grant);
      check("rnd_busy", bus.busy, m_owner >= 0);
      check("rnd_tx_valid", bus.tx_valid, e_tv);
      check("rnd_tx_data", bus.tx_data, e_td);
      check("rnd_req_ready", bus.req_ready, e_rr);
      check("rnd_timeouts", bus.timeout_count, m_to);
      model_step();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit channel between NUM_REQ independent byte-stream requesters.
- Grants are message-atomic: once a requester is granted, it owns the channel until it transfers a byte with req_last set, or until it stalls for longer than GAP_TIMEOUT cycles.
- The block sits between the requester clients (command responder, debug logger, etc.) and uart_driver's tx_data/tx_valid/tx_ready port.
- Arbitration is round-robin.

Parameters:
- NUM_REQ, 4: number of requesters; minimum 2.
- DATA_BITS, 8: byte width; must match uart_driver.
- GAP_TIMEOUT, 65535: maximum consecutive cycles the granted requester may hold req_valid low mid-message before its grant is revoked; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*DATA_BITS  flattened bytes; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- req_last  input  NUM_REQ  marks the final byte of requester i's message.
- req_ready  output  NUM_REQ  byte accepted from requester i this cycle.
- tx_data  output  DATA_BITS  byte to uart_driver.
- tx_valid  output  1  byte valid to uart_driver.
- tx_ready  input  1  uart_driver idle/accepting.
- grant  output  NUM_REQ  one-hot current owner; all-zero when no owner.
- busy  output  1  high while in S_GRANT.
- timeout_count  output  16  saturating count of grants revoked by gap timeout.

Behaviour:
- Reset (rst low, asynchronous):
  - state=S_IDLE, grant=0, last_grant pointer=NUM_REQ-1 (so requester 0 has first priority), gap counter=0, timeout_count=0.
  - Outputs go low immediately: tx_valid=0, req_ready=0, busy=0, tx_data=0.
- States:
  - S_IDLE: no owner.
  - S_GRANT: owner index gnt is registered.
- S_IDLE:
  - If any req_valid is high, select the first asserted requester searching cyclically from last_grant+1.
  - Register gnt and go to S_GRANT. That is 1 cycle of arbitration latency; nothing is forwarded in S_IDLE.
  - If no req_valid is high, stay in S_IDLE.
- S_GRANT datapath, all combinational from registered gnt:
  - tx_data = req_data[gnt].
  - tx_valid = req_valid[gnt].
  - req_ready[gnt] = tx_ready; all other req_ready bits = 0.
- A byte transfers when tx_valid && tx_ready.
- Transfer with req_last[gnt] high:
  - Next state is S_IDLE, last_grant<=gnt, gap counter cleared.
  - At least one idle cycle separates messages.
- Gap counter, in S_GRANT:
  - Increments on cycles where req_valid[gnt]=0.
  - Clears on any cycle where req_valid[gnt]=1, including while stalled on tx_ready=0, because a UART-busy stall is not a gap.
- Timeout: if req_valid[gnt]=0 and the gap counter equals GAP_TIMEOUT-1:
  - Go to S_IDLE, last_grant<=gnt, and timeout_count increments, saturating at 16'hFFFF.
  - The revoked requester's remaining bytes are treated as a new message at its next grant.
- Width rules:
  - The gap counter is $clog2(GAP_TIMEOUT+1) bits.
  - gnt is $clog2(NUM_REQ) bits.
  - The cyclic search wraps from NUM_REQ-1 to 0.
- Simultaneous events:
  - A last-byte transfer and valid requests from others in the same cycle: the new owner is picked in the following S_IDLE cycle from the updated pointer.
  - The owner raising req_valid on the exact timeout cycle: valid wins, so there is no timeout.
- Non-owners may hold req_valid high indefinitely. Their req_ready stays 0, and their data is ignored and not required to be stable.
- Mid-message reset: the grant is dropped immediately. A byte already latched by uart_driver finishes independently, because uart_driver has its own reset.

Optional Feature:
- Macro: UART_TX_ARB_PRIORITY_EN.
- Defined: requester 0 is strict high priority in S_IDLE. If req_valid[0] is high it wins regardless of last_grant, and last_grant is not updated when requester 0 finishes. Remaining requesters rotate round-robin among themselves. An in-progress grant is never preempted.
- Undefined: pure round-robin across all requesters, as above.

Test Plan:
- Single message: requester 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) with tx_ready pulsing high for 1 cycle every 100 cycles -> grant=4'b0100 one cycle after req_valid; tx_data sequence 0x41,0x42,0x43; one req_ready pulse per byte; S_IDLE after 0x43.
- Fairness: all 4 requesters continuously send 1-byte messages (last=1) -> grant order 0,1,2,3,0,1 starting from reset.
- Atomicity: requester 1 sends a 4-byte message while requester 0 asserts valid throughout -> all 4 bytes of requester 1 appear contiguously before any byte of requester 0.
- Timeout: GAP_TIMEOUT=8; requester 3 sends 1 byte without last, then drops valid -> exactly 8 cycles later busy=0 and timeout_count=1. In a separate run, valid held with tx_ready=0 for 1000 cycles -> no timeout.
- Async reset mid-message: assert rst low between bytes 2 and 3 -> tx_valid, req_ready, grant and busy all 0 in the same cycle; after release, timeout_count=0 and a fresh arbitration starts with requester 0 first.
- With UART_TX_ARB_PRIORITY_EN defined: requesters 0 and 2 valid at the same time after requester 0 just finished -> requester 0 is granted again.
